// File: rtl/hdlc_rx_clk_ctrl.sv
// Configuration sequencer and external-clock health monitor for the HDLC receive clock generator.
// Reconfigures the generator glitch-free: disable, quiesce, load, then re-enable.
module hdlc_rx_clk_ctrl #(
    parameter int unsigned QUIESCE_CYCLES = 4,
    parameter int unsigned LOSS_TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cfg_enable,
    input  logic        cfg_wr,
    input  logic [11:0] cfg_baud_freq,
    input  logic [15:0] cfg_baud_limit,
    input  logic        cfg_sync_mode,
    input  logic        clr_lost,
    input  logic        sample_en,
    output logic        gen_en,
    output logic        gen_load,
    output logic [11:0] gen_baud_freq,
    output logic [15:0] gen_baud_limit,
    output logic        gen_sync_mode,
    output logic        busy,
    output logic        cfg_ack,
    output logic        cfg_err,
    output logic        clk_lost
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RUN     = 2'd1;
    localparam logic [1:0] QUIESCE = 2'd2;
    localparam logic [1:0] LOAD    = 2'd3;

    localparam logic [7:0]  QUIESCE_LAST = 8'(QUIESCE_CYCLES - 1);
    localparam logic [15:0] LOSS_LIMIT   = 16'(LOSS_TIMEOUT);

    logic [1:0]  state_q, state_d;
    logic [7:0]  q_cnt_q, q_cnt_d;
    logic [15:0] loss_cnt_q, loss_cnt_d;
    logic        accept;
    logic        err_d;
    logic        ack_d;
    logic        lost_d;
    logic        loss_active;

    always_comb begin
        state_d = state_q;
        q_cnt_d = q_cnt_q;
        accept  = 1'b0;
        err_d   = 1'b0;
        ack_d   = 1'b0;
        case (state_q)
            IDLE, RUN: begin
                // A write, accepted or not, takes priority over enable changes.
                if (cfg_wr) begin
                    if (cfg_baud_freq != 12'd0 && cfg_baud_limit != 16'd0) begin
                        accept  = 1'b1;
                        state_d = QUIESCE;
                        q_cnt_d = 8'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (state_q == IDLE && cfg_enable) begin
                    state_d = RUN;
                end else if (state_q == RUN && !cfg_enable) begin
                    state_d = IDLE;
                end
            end
            QUIESCE: begin
                err_d = cfg_wr;
                if (q_cnt_q == QUIESCE_LAST) begin
                    state_d = LOAD;
                    q_cnt_d = 8'd0;
                end else begin
                    q_cnt_d = q_cnt_q + 8'd1;
                end
            end
            default: begin
                err_d   = cfg_wr;
                ack_d   = 1'b1;
                state_d = cfg_enable ? RUN : IDLE;
            end
        endcase
    end

    // Loss monitor only runs while the generator is live on an external clock.
    assign loss_active = (state_q == RUN) && gen_sync_mode;

    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if (!loss_active || clr_lost || sample_en) begin
            loss_cnt_d = 16'd0;
        end else if (loss_cnt_q != 16'hffff) begin
            loss_cnt_d = loss_cnt_q + 16'd1;
        end
        lost_d = clr_lost ? 1'b0 : (clk_lost || (loss_cnt_q >= LOSS_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            q_cnt_q        <= 8'd0;
            loss_cnt_q     <= 16'd0;
            gen_en         <= 1'b0;
            gen_load       <= 1'b0;
            gen_baud_freq  <= 12'd4;
            gen_baud_limit <= 16'd1;
            gen_sync_mode  <= 1'b0;
            busy           <= 1'b0;
            cfg_ack        <= 1'b0;
            cfg_err        <= 1'b0;
            clk_lost       <= 1'b0;
        end else begin
            state_q    <= state_d;
            q_cnt_q    <= q_cnt_d;
            loss_cnt_q <= loss_cnt_d;
            gen_en     <= (state_d == RUN);
            gen_load   <= (state_d == LOAD);
            busy       <= (state_d == QUIESCE) || (state_d == LOAD);
            cfg_ack    <= ack_d;
            cfg_err    <= err_d;
            clk_lost   <= lost_d;
            if (accept) begin
                gen_baud_freq  <= cfg_baud_freq;
                gen_baud_limit <= cfg_baud_limit;
                gen_sync_mode  <= cfg_sync_mode;
            end
        end
    end

endmodule

// File: tb/tb_hdlc_rx_clk_ctrl.sv
// Directed testbench for hdlc_rx_clk_ctrl with QUIESCE_CYCLES=4 and LOSS_TIMEOUT=1024.
module tb_hdlc_rx_clk_ctrl;

    logic        clk;
    logic        rst;
    logic        cfg_enable;
    logic        cfg_wr;
    logic [11:0] cfg_baud_freq;
    logic [15:0] cfg_baud_limit;
    logic        cfg_sync_mode;
    logic        clr_lost;
    logic        sample_en;
    logic        gen_en;
    logic        gen_load;
    logic [11:0] gen_baud_freq;
    logic [15:0] gen_baud_limit;
    logic        gen_sync_mode;
    logic        busy;
    logic        cfg_ack;
    logic        cfg_err;
    logic        clk_lost;

    int total;
    int bad;

    hdlc_rx_clk_ctrl #(
        .QUIESCE_CYCLES(4),
        .LOSS_TIMEOUT  (1024)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_enable    (cfg_enable),
        .cfg_wr        (cfg_wr),
        .cfg_baud_freq (cfg_baud_freq),
        .cfg_baud_limit(cfg_baud_limit),
        .cfg_sync_mode (cfg_sync_mode),
        .clr_lost      (clr_lost),
        .sample_en     (sample_en),
        .gen_en        (gen_en),
        .gen_load      (gen_load),
        .gen_baud_freq (gen_baud_freq),
        .gen_baud_limit(gen_baud_limit),
        .gen_sync_mode (gen_sync_mode),
        .busy          (busy),
        .cfg_ack       (cfg_ack),
        .cfg_err       (cfg_err),
        .clk_lost      (clk_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulses cfg_wr for one cycle; returns in cycle T+1.
    task automatic do_write(input logic [11:0] f, input logic [15:0] l, input logic s);
        cfg_wr = 1'b1;
        cfg_baud_freq = f;
        cfg_baud_limit = l;
        cfg_sync_mode = s;
        tick();
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cfg_enable = 1'b1;
        tick();
        tick();
        total++;
        if ({gen_en, gen_load, busy, cfg_ack, cfg_err, clk_lost, gen_sync_mode} !== 7'b0) begin
            bad++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {gen_en, gen_load, busy, cfg_ack, cfg_err, clk_lost, gen_sync_mode});
        end
        total++;
        if (gen_baud_freq !== 12'd4 || gen_baud_limit !== 16'd1) begin
            bad++;
            $display("FAIL reset_baud: got %0d/%0d want 4/1", gen_baud_freq, gen_baud_limit);
        end
        rst = 1'b0;
        tick();
        total++;
        if (gen_en !== 1'b1 || busy !== 1'b0 || gen_baud_freq !== 12'd4) begin
            bad++;
            $display("FAIL enable_run: got en=%b busy=%b freq=%0d want 1 0 4",
                     gen_en, busy, gen_baud_freq);
        end
    endtask

    task automatic test_write;
        do_write(12'd12, 16'd625, 1'b0);
        total++;
        if (gen_en !== 1'b0 || busy !== 1'b1 || gen_baud_freq !== 12'd12 ||
            gen_baud_limit !== 16'd625 || gen_load !== 1'b0) begin
            bad++;
            $display("FAIL write_t1: got en=%b busy=%b f=%0d l=%0d load=%b want 0 1 12 625 0",
                     gen_en, busy, gen_baud_freq, gen_baud_limit, gen_load);
        end
        for (int i = 2; i <= 4; i++) begin
            tick();
            total++;
            if (gen_en !== 1'b0 || gen_load !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL write_quiesce T+%0d: got en=%b load=%b busy=%b want 0 0 1",
                         i, gen_en, gen_load, busy);
            end
        end
        tick();
        total++;
        if (gen_load !== 1'b1 || gen_en !== 1'b0 || busy !== 1'b1 || cfg_ack !== 1'b0) begin
            bad++;
            $display("FAIL write_load: got load=%b en=%b busy=%b ack=%b want 1 0 1 0",
                     gen_load, gen_en, busy, cfg_ack);
        end
        tick();
        total++;
        if (cfg_ack !== 1'b1 || gen_en !== 1'b1 || busy !== 1'b0 || gen_load !== 1'b0) begin
            bad++;
            $display("FAIL write_ack: got ack=%b en=%b busy=%b load=%b want 1 1 0 0",
                     cfg_ack, gen_en, busy, gen_load);
        end
        tick();
        total++;
        if (cfg_ack !== 1'b0 || gen_en !== 1'b1) begin
            bad++;
            $display("FAIL write_after: got ack=%b en=%b want 0 1", cfg_ack, gen_en);
        end
    endtask

    task automatic test_reject;
        do_write(12'd0, 16'd100, 1'b0);
        total++;
        if (cfg_err !== 1'b1 || gen_en !== 1'b1 || busy !== 1'b0 ||
            gen_baud_freq !== 12'd12 || gen_baud_limit !== 16'd625) begin
            bad++;
            $display("FAIL reject_zero: got err=%b en=%b busy=%b f=%0d l=%0d want 1 1 0 12 625",
                     cfg_err, gen_en, busy, gen_baud_freq, gen_baud_limit);
        end
        tick();
        total++;
        if (cfg_err !== 1'b0 || gen_en !== 1'b1) begin
            bad++;
            $display("FAIL reject_after: got err=%b en=%b want 0 1", cfg_err, gen_en);
        end
        do_write(12'd20, 16'd50, 1'b0);
        cfg_wr = 1'b1;
        cfg_baud_freq = 12'd7;
        cfg_baud_limit = 16'd9;
        tick();
        cfg_wr = 1'b0;
        total++;
        if (cfg_err !== 1'b1 || busy !== 1'b1 || gen_baud_freq !== 12'd20 ||
            gen_baud_limit !== 16'd50) begin
            bad++;
            $display("FAIL reject_busy: got err=%b busy=%b f=%0d l=%0d want 1 1 20 50",
                     cfg_err, busy, gen_baud_freq, gen_baud_limit);
        end
        tick();
        tick();
        total++;
        if (gen_load !== 1'b0 || gen_en !== 1'b0 || cfg_err !== 1'b0) begin
            bad++;
            $display("FAIL reject_t4: got load=%b en=%b err=%b want 0 0 0",
                     gen_load, gen_en, cfg_err);
        end
        tick();
        total++;
        if (gen_load !== 1'b1) begin
            bad++;
            $display("FAIL reject_load_t5: got %b want 1", gen_load);
        end
        tick();
        total++;
        if (cfg_ack !== 1'b1 || gen_en !== 1'b1 || gen_baud_freq !== 12'd20) begin
            bad++;
            $display("FAIL reject_ack: got ack=%b en=%b f=%0d want 1 1 20",
                     cfg_ack, gen_en, gen_baud_freq);
        end
    endtask

    task automatic test_loss;
        sample_en = 1'b0;
        do_write(12'd12, 16'd625, 1'b1);
        repeat (5) tick();
        total++;
        if (gen_en !== 1'b1 || gen_sync_mode !== 1'b1 || clk_lost !== 1'b0) begin
            bad++;
            $display("FAIL loss_start: got en=%b sync=%b lost=%b want 1 1 0",
                     gen_en, gen_sync_mode, clk_lost);
        end
        repeat (1000) tick();
        sample_en = 1'b1;
        tick();
        sample_en = 1'b0;
        total++;
        if (clk_lost !== 1'b0) begin
            bad++;
            $display("FAIL loss_restart: got %b want 0", clk_lost);
        end
        repeat (1024) tick();
        total++;
        if (clk_lost !== 1'b0) begin
            bad++;
            $display("FAIL loss_early: got %b want 0", clk_lost);
        end
        tick();
        total++;
        if (clk_lost !== 1'b1) begin
            bad++;
            $display("FAIL loss_set: got %b want 1", clk_lost);
        end
        sample_en = 1'b1;
        repeat (3) tick();
        sample_en = 1'b0;
        total++;
        if (clk_lost !== 1'b1) begin
            bad++;
            $display("FAIL loss_sticky: got %b want 1", clk_lost);
        end
        clr_lost = 1'b1;
        tick();
        clr_lost = 1'b0;
        total++;
        if (clk_lost !== 1'b0) begin
            bad++;
            $display("FAIL loss_clear: got %b want 0", clk_lost);
        end
        tick();
        total++;
        if (clk_lost !== 1'b0) begin
            bad++;
            $display("FAIL loss_clear_hold: got %b want 0", clk_lost);
        end
    endtask

    task automatic test_disable;
        do_write(12'd30, 16'd40, 1'b0);
        cfg_enable = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            tick();
            total++;
            if (gen_en !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL disable_quiesce T+%0d: got en=%b busy=%b want 0 1",
                         i, gen_en, busy);
            end
        end
        tick();
        total++;
        if (gen_load !== 1'b1) begin
            bad++;
            $display("FAIL disable_load: got %b want 1", gen_load);
        end
        tick();
        total++;
        if (cfg_ack !== 1'b1 || gen_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL disable_ack: got ack=%b en=%b busy=%b want 1 0 0",
                     cfg_ack, gen_en, busy);
        end
        tick();
        total++;
        if (gen_en !== 1'b0 || cfg_ack !== 1'b0) begin
            bad++;
            $display("FAIL disable_idle: got en=%b ack=%b want 0 0", gen_en, cfg_ack);
        end
    endtask

    task automatic test_reset_mid;
        int loads;
        cfg_enable = 1'b1;
        tick();
        total++;
        if (gen_en !== 1'b1) begin
            bad++;
            $display("FAIL mid_run: got %b want 1", gen_en);
        end
        do_write(12'd50, 16'd60, 1'b1);
        total++;
        if (busy !== 1'b1 || gen_baud_freq !== 12'd50) begin
            bad++;
            $display("FAIL mid_quiesce: got busy=%b f=%0d want 1 50", busy, gen_baud_freq);
        end
        rst = 1'b1;
        tick();
        total++;
        if ({gen_en, gen_load, busy, cfg_ack, cfg_err, clk_lost, gen_sync_mode} !== 7'b0 ||
            gen_baud_freq !== 12'd4 || gen_baud_limit !== 16'd1) begin
            bad++;
            $display("FAIL mid_reset: got flags=%b f=%0d l=%0d want 0000000 4 1",
                     {gen_en, gen_load, busy, cfg_ack, cfg_err, clk_lost, gen_sync_mode},
                     gen_baud_freq, gen_baud_limit);
        end
        rst = 1'b0;
        cfg_enable = 1'b0;
        loads = 0;
        repeat (8) begin
            tick();
            if (gen_load === 1'b1 || cfg_ack === 1'b1) loads++;
        end
        total++;
        if (loads !== 0 || gen_en !== 1'b0) begin
            bad++;
            $display("FAIL mid_no_load: got loads=%0d en=%b want 0 0", loads, gen_en);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        rst = 1'b1;
        cfg_enable = 1'b0;
        cfg_wr = 1'b0;
        cfg_baud_freq = 12'd0;
        cfg_baud_limit = 16'd0;
        cfg_sync_mode = 1'b0;
        clr_lost = 1'b0;
        sample_en = 1'b0;
        test_reset();
        test_write();
        test_reject();
        test_loss();
        test_disable();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
